// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared constants, mode enum and address helper for the LCD bus decoder
// Contents: opcode masks, DDRAM row bases and wrap limits, SPACE fill byte,
//           mode_t {M8, HI, LO}, next_addr() and is_funcset() helpers.
package lcd_pkg;

    localparam logic [7:0] SPACE = 8'h20;

    localparam logic [6:0] ROW_A_BASE = 7'h00;
    localparam logic [6:0] ROW_B_BASE = 7'h40;
    localparam logic [6:0] ROW_A_WRAP = 7'h27;
    localparam logic [6:0] ROW_B_WRAP = 7'h67;

    // A command is identified by its highest set bit.
    localparam logic [7:0] OP_CLEAR   = 8'h01;
    localparam logic [7:0] OP_HOME    = 8'h02;
    localparam logic [7:0] OP_ENTRY   = 8'h04;
    localparam logic [7:0] OP_DISPCTL = 8'h08;
    localparam logic [7:0] OP_SHIFT   = 8'h10;
    localparam logic [7:0] OP_FUNCSET = 8'h20;
    localparam logic [7:0] OP_CGRAM   = 8'h40;
    localparam logic [7:0] OP_DDRAM   = 8'h80;

    typedef enum logic [1:0] {M8, HI, LO} mode_t;

    // DDRAM address step with the two-line wrap points; out-of-map
    // addresses simply count until they reach a wrap point.
    function automatic logic [6:0] next_addr(input logic [6:0] a, input logic inc);
        if (inc) begin
            if (a == ROW_A_WRAP)      return ROW_B_BASE;
            else if (a == ROW_B_WRAP) return ROW_A_BASE;
            else                      return a + 7'd1;
        end else begin
            if (a == ROW_B_BASE)      return ROW_A_WRAP;
            else if (a == ROW_A_BASE) return ROW_B_WRAP;
            else                      return a - 7'd1;
        end
    endfunction

    function automatic logic is_funcset(input logic [7:0] b);
        return (b & 8'hE0) == OP_FUNCSET;
    endfunction

endpackage

// File: rtl/lcd_bus_decoder_sync.sv
// rtl/lcd_bus_decoder_sync.sv - bus input synchronizer with registered E falling-edge pulse
// Ports: clk, reset (async, high); e, rs, rw, d[3:0] raw bus;
//        e_fall 1-cycle pulse; rs_q, rw_q, d_q bus fields taken from the same stage as E.
module lcd_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       e,
    input  logic       rs,
    input  logic       rw,
    input  logic [3:0] d,
    output logic       e_fall,
    output logic       rs_q,
    output logic       rw_q,
    output logic [3:0] d_q
);

    // {E, RS, RW, D[3:0]} travel together so the fields stay aligned with E.
    logic [6:0] stage [SYNC_STAGES];
    logic       e_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
            e_last <= 1'b0;
            e_fall <= 1'b0;
            rs_q   <= 1'b0;
            rw_q   <= 1'b0;
            d_q    <= 4'h0;
        end else begin
            stage[0] <= {e, rs, rw, d};
            for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
            e_last <= stage[SYNC_STAGES-1][6];
            e_fall <= e_last & ~stage[SYNC_STAGES-1][6];
            {rs_q, rw_q, d_q} <= stage[SYNC_STAGES-1][5:0];
        end
    end

endmodule

// File: rtl/lcd_bus_decoder.sv
// rtl/lcd_bus_decoder.sv - HD44780 4-bit bus receiver with 2x16 character shadow
// Ports: clk, reset (async, high); LCD_RS, LCD_RW, LCD_E, LCD_D[3:0] bus inputs;
//        row_A/row_B[127:0] shadow rows ([127:120] = column 0); display_on;
//        cmd_valid/char_valid commit pulses with byte_out; proto_err, timing_err pulses.
// Optional: define LCD_BUSY_CHECK_EN to model controller busy time and flag early transfers.
module lcd_bus_decoder
    import lcd_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int BUSY_SHORT  = 2000,
    parameter int BUSY_LONG   = 82000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         LCD_RS,
    input  logic         LCD_RW,
    input  logic         LCD_E,
    input  logic [3:0]   LCD_D,
    output logic [127:0] row_A,
    output logic [127:0] row_B,
    output logic         display_on,
    output logic         cmd_valid,
    output logic         char_valid,
    output logic [7:0]   byte_out,
    output logic         proto_err,
    output logic         timing_err
);

    logic       e_fall, rs_s, rw_s;
    logic [3:0] d_s;

    lcd_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .reset  (reset),
        .e      (LCD_E),
        .rs     (LCD_RS),
        .rw     (LCD_RW),
        .d      (LCD_D),
        .e_fall (e_fall),
        .rs_q   (rs_s),
        .rw_q   (rw_s),
        .d_q    (d_s)
    );

    mode_t      mode;
    logic [3:0] hi_nib;
    logic       hi_rs, hi_rw;
    logic [6:0] addr;
    logic       inc;
    logic       cgram;

    logic       commit, c_rs, perr, clr_home;
    logic [7:0] c_byte;
    logic [6:0] col_lsb;

    // Byte being committed on this edge, if any.
    always_comb begin
        commit = 1'b0;
        c_byte = 8'h00;
        c_rs   = 1'b0;
        perr   = 1'b0;
        if (e_fall) begin
            if (mode == M8) begin
                commit = !rw_s;
                c_byte = {d_s, 4'h0};
                c_rs   = rs_s;
            end else if (mode == LO) begin
                commit = !(hi_rw || rw_s);
                c_byte = {hi_nib, d_s};
                c_rs   = hi_rs;
                perr   = commit && (rs_s != hi_rs);
            end
        end
    end

    assign clr_home = !c_rs && (c_byte[7:2] == 6'd0) && (c_byte[1:0] != 2'd0);
    // Column 0 sits in the top byte, so the bit offset is (15 - col) * 8.
    assign col_lsb  = {~addr[3:0], 3'b000};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode       <= M8;
            hi_nib     <= 4'h0;
            hi_rs      <= 1'b0;
            hi_rw      <= 1'b0;
            addr       <= ROW_A_BASE;
            inc        <= 1'b1;
            cgram      <= 1'b0;
            display_on <= 1'b0;
            byte_out   <= 8'h00;
            cmd_valid  <= 1'b0;
            char_valid <= 1'b0;
            proto_err  <= 1'b0;
            row_A      <= {16{SPACE}};
            row_B      <= {16{SPACE}};
        end else begin
            cmd_valid  <= 1'b0;
            char_valid <= 1'b0;
            proto_err  <= perr;

            if (e_fall) begin
                case (mode)
                    M8: if (commit && !c_rs && is_funcset(c_byte) && !c_byte[4]) mode <= HI;
                    HI: begin
                        hi_nib <= d_s;
                        hi_rs  <= rs_s;
                        hi_rw  <= rw_s;
                        mode   <= LO;
                    end
                    LO: mode <= (commit && !c_rs && is_funcset(c_byte) && c_byte[4]) ? M8 : HI;
                    default: mode <= M8;
                endcase
            end

            if (commit) begin
                byte_out <= c_byte;
                if (c_rs) begin
                    char_valid <= 1'b1;
                    // CGRAM data has no shadow; the DDRAM address is left alone.
                    if (!cgram) begin
                        if (addr[6:4] == ROW_A_BASE[6:4])      row_A[col_lsb +: 8] <= c_byte;
                        else if (addr[6:4] == ROW_B_BASE[6:4]) row_B[col_lsb +: 8] <= c_byte;
                        addr <= next_addr(addr, inc);
                    end
                end else begin
                    cmd_valid <= 1'b1;
                    if (|(c_byte & OP_DDRAM)) begin
                        addr  <= c_byte[6:0];
                        cgram <= 1'b0;
                    end else if (|(c_byte & OP_CGRAM)) begin
                        cgram <= 1'b1;
                    end else if (|(c_byte & (OP_FUNCSET | OP_SHIFT))) begin
                        // function set only affects mode; shifts are not modelled
                    end else if (|(c_byte & OP_DISPCTL)) begin
                        display_on <= c_byte[2];
                    end else if (|(c_byte & OP_ENTRY)) begin
                        inc <= c_byte[1];
                    end else if (|(c_byte & OP_HOME)) begin
                        addr  <= ROW_A_BASE;
                        cgram <= 1'b0;
                    end else if (|(c_byte & OP_CLEAR)) begin
                        row_A <= {16{SPACE}};
                        row_B <= {16{SPACE}};
                        addr  <= ROW_A_BASE;
                        inc   <= 1'b1;
                        cgram <= 1'b0;
                    end
                end
            end
        end
    end

`ifdef LCD_BUSY_CHECK_EN
    localparam int BW = $clog2(BUSY_LONG + 1);
    logic [BW-1:0] busy_cnt;

    // Busy model runs only once the bus is in 4-bit mode; in M8 the host
    // uses its own fixed init delays.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_cnt   <= '0;
            timing_err <= 1'b0;
        end else begin
            timing_err <= e_fall && (mode != M8) && (busy_cnt != '0);
            if (commit && (mode != M8))
                busy_cnt <= clr_home ? BW'(BUSY_LONG) : BW'(BUSY_SHORT);
            else if (busy_cnt != '0)
                busy_cnt <= busy_cnt - 1'b1;
        end
    end
`else
    assign timing_err = 1'b0;
    logic unused_busy;
    assign unused_busy = clr_home;
`endif

endmodule
